// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: NOP encoding, default reset PC,
// FSM state encodings and a word-alignment helper.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_gnt, input imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_inst_fifo.sv
// DEPTH-entry synchronous FIFO of {inst, pc} with flush; the head entry is
// read combinationally from registered storage.
module if_inst_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [31:0]              i_push_inst,
  input  logic [31:0]              i_push_pc,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_head_inst,
  output logic [31:0]              o_head_pc
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] r_inst [DEPTH];
  logic [31:0] r_pc   [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_inst[r_wptr] <= i_push_inst;
      r_pc[r_wptr]   <= i_push_pc;
    end
  end

  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_inst = r_inst[r_rptr];
  assign o_head_pc   = r_pc[r_rptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited reads to a
// variable-latency memory, buffers responses and handles jump redirects.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  if_fetch_stage_if.master         imem,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_pc4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_state_e      r_state, w_state_nxt;
  logic [31:0]    r_fetch_pc, w_fetch_pc_nxt;
  logic [CW-1:0]  r_outstanding, w_outstanding_nxt;
  logic [CW-1:0]  r_drop_cnt, w_drop_cnt_nxt, w_drop_calc;
  logic [31:0]    r_pcq [DEPTH];
  logic [AW-1:0]  r_pcq_wptr, r_pcq_rptr;

  logic           w_fifo_full, w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;
  logic [31:0]    w_head_inst, w_head_pc;
  logic           w_pop, w_req, w_gnt, w_rsp, w_push, w_flush, w_credit;
  logic [CW:0]    w_inflight;

  assign w_pop = !w_fifo_empty && !stall;

  // A slot popped this cycle is already free, which keeps a 1-cycle memory at
  // one instruction per cycle without risking overflow.
  assign w_inflight = (CW+1)'(w_fifo_count) + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
  assign w_credit   = (w_inflight < (CW+1)'(DEPTH)) && !(w_fifo_full && !w_pop);

  assign w_req   = (r_state == IF_FETCH) && w_credit;
  assign w_gnt   = w_req && imem.imem_gnt;
  assign w_rsp   = (r_state == IF_FETCH) && imem.imem_rvalid && (r_outstanding != '0);
  assign w_flush = redirect && (r_state != IF_IDLE);
  assign w_push  = w_rsp && !redirect;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;
    w_drop_calc       = '0;
    case (r_state)
      IF_IDLE: w_state_nxt = IF_FETCH;
      IF_FETCH: begin
        w_drop_calc = r_outstanding + CW'(w_gnt) - CW'(w_rsp);
        if (redirect) begin
          w_fetch_pc_nxt    = word_align(redirect_pc);
          w_outstanding_nxt = '0;
          w_drop_cnt_nxt    = w_drop_calc;
          w_state_nxt       = (w_drop_calc != '0) ? IF_DRAIN : IF_FETCH;
        end else begin
          w_outstanding_nxt = w_drop_calc;
          if (w_gnt) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      IF_DRAIN: begin
        w_drop_calc    = r_drop_cnt - CW'(imem.imem_rvalid && (r_drop_cnt != '0));
        w_drop_cnt_nxt = w_drop_calc;
        if (redirect) w_fetch_pc_nxt = word_align(redirect_pc);
        if (w_drop_calc == '0) w_state_nxt = IF_FETCH;
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IF_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_pcq_wptr    <= '0;
      r_pcq_rptr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      if (w_flush) begin
        r_pcq_wptr <= '0;
        r_pcq_rptr <= '0;
      end else begin
        if (w_gnt) r_pcq_wptr <= r_pcq_wptr + 1'b1;
        if (w_rsp) r_pcq_rptr <= r_pcq_rptr + 1'b1;
      end
    end
  end

  // PC of every granted request, matched to its in-order response.
  always_ff @(posedge clk) begin
    if (w_gnt && !w_flush) r_pcq[r_pcq_wptr] <= r_fetch_pc;
  end

  if_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_inst (imem.imem_rdata),
    .i_push_pc   (r_pcq[r_pcq_rptr]),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head_inst (w_head_inst),
    .o_head_pc   (w_head_pc)
  );

  assign inst_valid = !w_fifo_empty;
  assign inst       = w_fifo_empty ? NOP_INST : w_head_inst;
  assign inst_pc    = w_fifo_empty ? 32'h0 : w_head_pc;
  assign inst_pc4   = inst_pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: in-order memory model with settable
// latency/grant, and a scoreboard of expected PCs checked on every consume.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, inst_pc4;

  always #5 clk = ~clk;

  if_fetch_stage_if imem_if();

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_if),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc, lat, consumed;
  logic        gnt_ctl;
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_pc, held_pc;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic load_exp(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: drive memory inputs after negedge, sample before posedge.
  task automatic step();
    logic [31:0] e;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_if.imem_rvalid = 1'b1;
      imem_if.imem_rdata  = ~mq[0].addr;
      void'(mq.pop_front());
    end
    imem_if.imem_gnt = gnt_ctl;
    #4;
    s_req    = imem_if.imem_req;
    s_addr   = imem_if.imem_addr;
    s_valid  = inst_valid;
    s_pc     = inst_pc;
    s_rvalid = imem_if.imem_rvalid;
    if (imem_if.imem_req && imem_if.imem_gnt) mq.push_back('{imem_if.imem_addr, cyc + lat});
    if (inst_valid && !stall) begin
      consumed++;
      if (exp_q.size() == 0) check_val("sb_extra_inst", inst_pc, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check_val("inst_pc", inst_pc, e);
        check_val("inst_pc4", inst_pc4, e + 32'd4);
        check_val("inst", inst, ~e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    gnt_ctl  = 1'b1;
    lat      = 1;
    mq.delete();
    exp_q.delete();
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = 32'h0;
    imem_if.imem_gnt    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    consumed = 0;
  endtask

  task automatic check_reset_outputs(input string sfx);
    check_val({"rst_req", sfx},   32'(imem_if.imem_req), 32'h0);
    check_val({"rst_addr", sfx},  imem_if.imem_addr, 32'h0);
    check_val({"rst_valid", sfx}, 32'(inst_valid), 32'h0);
    check_val({"rst_inst", sfx},  inst, NOP_INST);
    check_val({"rst_pc", sfx},    inst_pc, 32'h0);
    check_val({"rst_pc4", sfx},   inst_pc4, 32'h4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    gnt_ctl = 1'b1; lat = 1; cyc = 0; consumed = 0; held_pc = 32'h0;
    imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = 32'h0;
    #1;
    check_reset_outputs("_init");
    @(negedge clk);

    // Cold start, 1-cycle memory: first valid 3 cycles after release, then 1/cycle.
    do_reset();
    load_exp(32'h0, 32);
    step();
    check_val("idle_req", 32'(s_req), 32'h0);
    step();
    check_val("first_req", 32'(s_req), 32'h1);
    check_val("first_addr", s_addr, 32'h0);
    step();
    check_val("k2_valid", 32'(s_valid), 32'h0);
    for (int k = 3; k <= 10; k++) begin
      step();
      check_val("stream_valid", 32'(s_valid), 32'h1);
    end
    check_val("t1_consumed", 32'(consumed), 32'd8);

    // Grant withheld: address and request held until accepted.
    do_reset();
    load_exp(32'h0, 48);
    gnt_ctl = 1'b0;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      check_val("nognt_req", 32'(s_req), 32'h1);
      check_val("nognt_addr", s_addr, 32'h0);
    end
    gnt_ctl = 1'b1;
    step();
    check_val("gnt_addr", s_addr, 32'h0);
    step();
    check_val("post_gnt_addr", s_addr, 32'h4);
    repeat (6) step();

    // Stall: buffer fills, requests stop, head held; release resumes in order.
    stall = 1'b1;
    step();
    held_pc = s_pc;
    repeat (4) step();
    check_val("stall_req", 32'(s_req), 32'h0);
    check_val("stall_valid", 32'(s_valid), 32'h1);
    check_val("stall_pc_hold", s_pc, held_pc);
    stall = 1'b0;
    repeat (10) step();

    // Redirect with two responses outstanding on a 3-cycle memory.
    do_reset();
    lat = 3;
    load_exp(32'h0, 4);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    check_val("rd_busy_req", 32'(s_req), 32'h0);
    redirect = 1'b0;
    load_exp(32'h100, 16);
    step();
    check_val("drain_req0", 32'(s_req), 32'h0);
    check_val("drain_valid0", 32'(s_valid), 32'h0);
    step();
    check_val("drain_req1", 32'(s_req), 32'h0);
    step();
    check_val("rd_target_req", 32'(s_req), 32'h1);
    check_val("rd_target_addr", s_addr, 32'h0000_0100);
    repeat (10) step();
    check_val("rd_consumed_any", 32'(consumed > 0), 32'h1);

    // Unaligned redirect coincident with grant and response.
    do_reset();
    load_exp(32'h0, 16);
    repeat (5) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    check_val("coin_req", 32'(s_req), 32'h1);
    check_val("coin_rvalid", 32'(s_rvalid), 32'h1);
    redirect = 1'b0;
    load_exp(32'h200, 16);
    step();
    check_val("coin_drain_req", 32'(s_req), 32'h0);
    check_val("coin_drain_valid", 32'(s_valid), 32'h0);
    step();
    check_val("coin_target_req", 32'(s_req), 32'h1);
    check_val("coin_target_addr", s_addr, 32'h0000_0200);
    repeat (8) step();

    // Asynchronous reset in the middle of a drain.
    do_reset();
    lat = 3;
    load_exp(32'h0, 4);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("_async");
    @(negedge clk);
    do_reset();
    load_exp(32'h0, 32);
    repeat (12) step();
    check_val("restart_consumed", 32'(consumed), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
